// File: rtl/hd_pkg.sv
// Shared constants and types for the hypervector encoding datapath.
package hd_pkg;

    localparam int Dhv_SIZE = 4000;
    localparam int Div_SIZE = 512;
    localparam int N_SIZE   = 16;
    localparam int M_SIZE   = 16;
    localparam int FTWIDTH  = 8;

    // Accumulator width: feature bits, growth over Div_SIZE terms, and a sign bit.
    function automatic int calc_accw(input int ftwidth, input int div_size);
        return ftwidth + $clog2(div_size) + 1;
    endfunction

    localparam int ACCW = calc_accw(FTWIDTH, Div_SIZE);

    typedef logic [FTWIDTH-1:0]     feature_t;
    typedef logic signed [ACCW-1:0] acc_t;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/hv_dot_lane.sv
// One hypervector lane: bipolar (+1/-1) dot product of a feature tile
// against an N_SIZE-bit weight slice. Purely combinational.
module hv_dot_lane #(
    parameter int N_SIZE  = hd_pkg::N_SIZE,
    parameter int FTWIDTH = hd_pkg::FTWIDTH,
    parameter int ACCW    = hd_pkg::ACCW
) (
    input  logic [N_SIZE-1:0][FTWIDTH-1:0] features,
    input  logic [N_SIZE-1:0]              weights,
    output logic signed [ACCW-1:0]         dot
);

    // Sum zero-extended features, adding where the weight bit is 1, subtracting otherwise.
    always_comb begin
        // NOTE: blocking assignments here build the running sum in loop order; a default first keeps this free of latches.
        dot = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            if (weights[i]) begin
                dot = dot + $signed({{(ACCW-FTWIDTH){1'b0}}, features[i]});
            end else begin
                dot = dot - $signed({{(ACCW-FTWIDTH){1'b0}}, features[i]});
            end
        end
    end

endmodule

// File: rtl/hv_tile_accumulator.sv
// Encoding MAC stage: accumulates Div_SIZE/N_SIZE tiles into M_SIZE signed
// hypervector elements, then holds the finished chunk until the controller clears.
module hv_tile_accumulator #(
    parameter int Dhv_SIZE = hd_pkg::Dhv_SIZE,
    parameter int Div_SIZE = hd_pkg::Div_SIZE,
    parameter int N_SIZE   = hd_pkg::N_SIZE,
    parameter int M_SIZE   = hd_pkg::M_SIZE,
    parameter int FTWIDTH  = hd_pkg::FTWIDTH,
    parameter int ACCW     = hd_pkg::calc_accw(FTWIDTH, Div_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   reset_in,
    input  logic                                   in_valid,
    input  logic [N_SIZE+M_SIZE-1:0]               in_projections,
    input  logic [N_SIZE-1:0][FTWIDTH-1:0]         in_features,
    input  logic                                   clear,
    output logic                                   done,
    output logic                                   hv_valid,
    output logic [M_SIZE-1:0][ACCW-1:0]            hv_sums,
    output logic [M_SIZE-1:0]                      hv_bits,
    output logic [$clog2(Dhv_SIZE/M_SIZE)-1:0]     chunk_idx
);

    import hd_pkg::*;

    localparam int K_TILES    = Div_SIZE / N_SIZE;
    localparam int CNTW       = $clog2(K_TILES);
    localparam int NUM_CHUNKS = Dhv_SIZE / M_SIZE;
    localparam int CIW        = $clog2(NUM_CHUNKS);

    state_t                 state;
    logic [CNTW-1:0]        tile_cnt;
    logic signed [ACCW-1:0] lane_dot [M_SIZE];
    logic signed [ACCW-1:0] acc_next [M_SIZE];
    logic                   last_tile;

    // The lane windows only reach bit N_SIZE+M_SIZE-2; the top bit carries no weight.
    logic unused_proj_msb;
    assign unused_proj_msb = in_projections[N_SIZE+M_SIZE-1];

    // One dot-product lane per hypervector element, each on a sliding projection window.
    for (genvar j = 0; j < M_SIZE; j++) begin : g_lane
        hv_dot_lane #(
            .N_SIZE  (N_SIZE),
            .FTWIDTH (FTWIDTH),
            .ACCW    (ACCW)
        ) u_lane (
            .features (in_features),
            .weights  (in_projections[j +: N_SIZE]),
            .dot      (lane_dot[j])
        );
    end

    // Candidate accumulator values if the current tile is accepted.
    always_comb begin
        for (int j = 0; j < M_SIZE; j++) begin
            acc_next[j] = $signed(hv_sums[j]) + lane_dot[j];
        end
    end

    assign last_tile = (tile_cnt == CNTW'(K_TILES - 1));

    // Chunk FSM with registered sums, bits, flags and chunk index.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_in) begin
            state     <= ACC;
            tile_cnt  <= '0;
            hv_sums   <= '0;
            hv_bits   <= '0;
            done      <= 1'b0;
            hv_valid  <= 1'b0;
            chunk_idx <= '0;
        end else begin
            hv_valid <= 1'b0;
            if (clear) begin
                state    <= ACC;
                tile_cnt <= '0;
                hv_sums  <= '0;
                hv_bits  <= '0;
                done     <= 1'b0;
                // Only a completed chunk advances the index; an abort restarts the same chunk.
                if (state == DONE) begin
                    if (chunk_idx == CIW'(NUM_CHUNKS - 1)) begin
                        chunk_idx <= '0;
                    end else begin
                        chunk_idx <= chunk_idx + CIW'(1);
                    end
                end
            end else begin
                case (state)
                    ACC: begin
                        if (in_valid) begin
                            for (int j = 0; j < M_SIZE; j++) begin
                                hv_sums[j] <= acc_next[j];
                                hv_bits[j] <= !acc_next[j][ACCW-1] && (acc_next[j] != '0);
                            end
                            if (last_tile) begin
                                tile_cnt <= '0;
                                state    <= DONE;
                                done     <= 1'b1;
                                hv_valid <= 1'b1;
                            end else begin
                                tile_cnt <= tile_cnt + CNTW'(1);
                            end
                        end
                    end
                    DONE: begin
                        // Frozen until clear; in_valid is ignored.
                    end
                    default: begin
                        state <= ACC;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hv_tile_accumulator.sv
// Directed bench for hv_tile_accumulator with hand-computed expectations.
module tb_hv_tile_accumulator;

    localparam int N  = 16;
    localparam int M  = 16;
    localparam int FW = 8;
    localparam int AW = 18;

    localparam logic [N+M-1:0] PROJ_ONES = 32'hFFFF_FFFF;
    localparam logic [N+M-1:0] PROJ_ZERO = 32'h0000_0000;
    localparam logic [N+M-1:0] PROJ_ALT  = 32'hAAAA_AAAA;

    logic                      clk;
    logic                      reset_in;
    logic                      in_valid;
    logic [N+M-1:0]            in_projections;
    logic [N-1:0][FW-1:0]      in_features;
    logic                      clear;
    logic                      done;
    logic                      hv_valid;
    logic [M-1:0][AW-1:0]      hv_sums;
    logic [M-1:0]              hv_bits;
    logic [7:0]                chunk_idx;

    int checks;
    int errors;
    int exp_chunk;

    hv_tile_accumulator dut (
        .clk            (clk),
        .reset_in       (reset_in),
        .in_valid       (in_valid),
        .in_projections (in_projections),
        .in_features    (in_features),
        .clear          (clear),
        .done           (done),
        .hv_valid       (hv_valid),
        .hv_sums        (hv_sums),
        .hv_bits        (hv_bits),
        .chunk_idx      (chunk_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tile k holds (16k+i) mod 256, or all ones when ones is set.
    task automatic drive_tile(input logic [N+M-1:0] proj, input int k, input bit ones);
        in_valid       = 1'b1;
        in_projections = proj;
        for (int i = 0; i < N; i++) begin
            in_features[i] = ones ? 8'd1 : 8'((16 * k + i) % 256);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (hv_valid !== 1'b0) begin errors++; $display("FAIL reset_hv_valid got %b want 0", hv_valid); end
        checks++; if (hv_bits !== 16'h0000) begin errors++; $display("FAIL reset_bits got %h want 0000", hv_bits); end
        checks++; if (chunk_idx !== 8'd0) begin errors++; $display("FAIL reset_chunk got %0d want 0", chunk_idx); end
        checks++; if (hv_sums !== '0) begin errors++; $display("FAIL reset_sums got %h want 0", hv_sums); end
    endtask

    task automatic test_reset_mid_chunk();
        logic [AW-1:0] exp10;
        exp10 = 18'd12720;
        for (int k = 0; k < 10; k++) drive_tile(PROJ_ONES, k, 1'b0);
        checks++; if (hv_sums[0] !== exp10) begin errors++; $display("FAIL mid_partial_sum got %0d want 12720", $signed(hv_sums[0])); end
        // Reset wins over an accompanying tile.
        reset_in       = 1'b0;
        in_valid       = 1'b1;
        tick();
        reset_in = 1'b1;
        in_valid = 1'b0;
        checks++; if (hv_sums !== '0) begin errors++; $display("FAIL mid_reset_sums got %h want 0", hv_sums); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got %b want 0", done); end
        checks++; if (chunk_idx !== 8'd0) begin errors++; $display("FAIL mid_reset_chunk got %0d want 0", chunk_idx); end
        for (int k = 0; k < 31; k++) drive_tile(PROJ_ONES, k, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_early_done got %b want 0 after 31 tiles", done); end
        drive_tile(PROJ_ONES, 31, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done got %b want 1 after 32 tiles", done); end
        do_clear();
        exp_chunk = 1;
        checks++; if (chunk_idx !== 8'(exp_chunk)) begin errors++; $display("FAIL mid_clear_chunk got %0d want %0d", chunk_idx, exp_chunk); end
    endtask

    task automatic test_positive_chunk();
        logic [AW-1:0] exp_pos;
        exp_pos = 18'd65280;
        for (int k = 0; k < 31; k++) drive_tile(PROJ_ONES, k, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pos_early_done got %b want 0", done); end
        checks++; if (hv_valid !== 1'b0) begin errors++; $display("FAIL pos_early_valid got %b want 0", hv_valid); end
        drive_tile(PROJ_ONES, 31, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pos_done got %b want 1", done); end
        checks++; if (hv_valid !== 1'b1) begin errors++; $display("FAIL pos_valid_pulse got %b want 1", hv_valid); end
        for (int j = 0; j < M; j++) begin
            checks++; if (hv_sums[j] !== exp_pos) begin errors++; $display("FAIL pos_sum lane %0d got %0d want 65280", j, $signed(hv_sums[j])); end
        end
        checks++; if (hv_bits !== 16'hFFFF) begin errors++; $display("FAIL pos_bits got %h want ffff", hv_bits); end
        tick();
        checks++; if (hv_valid !== 1'b0) begin errors++; $display("FAIL pos_valid_drop got %b want 0", hv_valid); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pos_done_hold got %b want 1", done); end
    endtask

    task automatic test_hold_and_clear();
        logic [AW-1:0] exp_pos;
        exp_pos = 18'd65280;
        for (int c = 0; c < 5; c++) begin
            drive_tile(PROJ_ONES, c + 3, 1'b0);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done cycle %0d got %b want 1", c, done); end
        end
        checks++; if (hv_sums[0] !== exp_pos || hv_sums[M-1] !== exp_pos) begin errors++; $display("FAIL hold_sums got %0d/%0d want 65280", $signed(hv_sums[0]), $signed(hv_sums[M-1])); end
        checks++; if (hv_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b want 0", hv_valid); end
        do_clear();
        exp_chunk++;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_done got %b want 0", done); end
        checks++; if (hv_sums !== '0) begin errors++; $display("FAIL clear_sums got %h want 0", hv_sums); end
        checks++; if (hv_bits !== 16'h0000) begin errors++; $display("FAIL clear_bits got %h want 0000", hv_bits); end
        checks++; if (chunk_idx !== 8'(exp_chunk)) begin errors++; $display("FAIL clear_chunk got %0d want %0d", chunk_idx, exp_chunk); end
    endtask

    task automatic test_negative_chunk();
        logic [AW-1:0] exp_neg;
        exp_neg = -18'sd65280;
        for (int k = 0; k < 32; k++) drive_tile(PROJ_ZERO, k, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL neg_done got %b want 1", done); end
        for (int j = 0; j < M; j++) begin
            checks++; if (hv_sums[j] !== exp_neg) begin errors++; $display("FAIL neg_sum lane %0d got %0d want -65280", j, $signed(hv_sums[j])); end
        end
        checks++; if (hv_bits !== 16'h0000) begin errors++; $display("FAIL neg_bits got %h want 0000", hv_bits); end
        do_clear();
        exp_chunk++;
        checks++; if (chunk_idx !== 8'(exp_chunk)) begin errors++; $display("FAIL neg_clear_chunk got %0d want %0d", chunk_idx, exp_chunk); end
    endtask

    task automatic test_clear_with_valid();
        logic [AW-1:0] exp_pos;
        exp_pos = 18'd65280;
        for (int k = 0; k < 3; k++) drive_tile(PROJ_ONES, k, 1'b0);
        clear = 1'b1;
        drive_tile(PROJ_ONES, 3, 1'b0);
        clear = 1'b0;
        checks++; if (hv_sums !== '0) begin errors++; $display("FAIL abort_sums got %h want 0", hv_sums); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (chunk_idx !== 8'(exp_chunk)) begin errors++; $display("FAIL abort_chunk got %0d want %0d", chunk_idx, exp_chunk); end
        // A restarted counter needs a full 32 tiles again.
        for (int k = 0; k < 31; k++) drive_tile(PROJ_ONES, k, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_early_done got %b want 0", done); end
        drive_tile(PROJ_ONES, 31, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done_after_32 got %b want 1", done); end
        checks++; if (hv_sums[5] !== exp_pos) begin errors++; $display("FAIL abort_sum got %0d want 65280", $signed(hv_sums[5])); end
        do_clear();
        exp_chunk++;
    endtask

    task automatic test_wrap_and_zero();
        reset_in = 1'b0;
        tick();
        reset_in  = 1'b1;
        exp_chunk = 0;
        for (int c = 0; c < 250; c++) begin
            for (int k = 0; k < 32; k++) drive_tile((c == 0) ? PROJ_ALT : PROJ_ONES, k, c == 0);
            if (c == 0) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
                checks++; if (hv_sums !== '0) begin errors++; $display("FAIL zero_sums got %h want 0", hv_sums); end
                checks++; if (hv_bits !== 16'h0000) begin errors++; $display("FAIL zero_bits got %h want 0000", hv_bits); end
            end
            if (c == 249) begin
                checks++; if (chunk_idx !== 8'd249) begin errors++; $display("FAIL wrap_last_chunk got %0d want 249", chunk_idx); end
            end
            do_clear();
            exp_chunk = (exp_chunk == 249) ? 0 : exp_chunk + 1;
        end
        checks++; if (chunk_idx !== 8'(exp_chunk)) begin errors++; $display("FAIL wrap_chunk got %0d want %0d", chunk_idx, exp_chunk); end
        checks++; if (chunk_idx !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", chunk_idx); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        exp_chunk      = 0;
        reset_in       = 1'b0;
        in_valid       = 1'b0;
        clear          = 1'b0;
        in_projections = '0;
        in_features    = '0;

        test_reset();
        test_reset_mid_chunk();
        test_positive_chunk();
        test_hold_and_clear();
        test_negative_chunk();
        test_clear_with_valid();
        test_wrap_and_zero();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
